// File: rtl/hex_display_arbiter_if.sv
// hex_display_arbiter_if
// Bundles the requester-side signals of the display arbiter.
//
// Handshake: requester i raises req[i] (a level) with req_value/req_blank
// slice i stable; the arbiter answers with a one-cycle gnt[i] pulse on the
// edge it captures that slice. req/data must stay stable until gnt[i] is
// seen. Dropping req[i] in the gnt cycle releases the display. Holding it
// requests another update, which competes round-robin after the dwell.
//
// Signals:
//   req        [2:0]   request level per requester
//   req_value  [71:0]  requester i value at [24i+23:24i], nibble d -> HEXd
//   req_blank  [17:0]  requester i blank mask at [6i+5:6i], bit d blanks HEXd
//   gnt        [2:0]   one-hot grant pulse
//   owner      [1:0]   requester currently shown, 2'd3 = none
//   busy               dwell timer running
// Modports: master = requester side, slave = arbiter side.
interface hex_display_arbiter_if;
    logic [2:0]  req;
    logic [71:0] req_value;
    logic [17:0] req_blank;
    logic [2:0]  gnt;
    logic [1:0]  owner;
    logic        busy;

    modport master (output req, req_value, req_blank, input gnt, owner, busy);
    modport slave  (input req, req_value, req_blank, output gnt, owner, busy);
endinterface

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
// Shares six 7-segment digits between three requesters. Grants round-robin,
// latches and decodes the winner's value onto HEX0-HEX5, then holds it for
// HOLD_CYCLES cycles before arbitrating again. All outputs are registered,
// so there is no combinational path from req to any output.
//
// Ports:
//   CLOCK_50    system clock, rising edge
//   reset       synchronous, active-high
//   bus         requester interface (slave modport)
//   HEX0..HEX5  active-low segments, bit0=a .. bit6=g, bit7=DP (always off)
//   state_dbg   current FSM state (0 = READY, 1 = HOLD)
module hex_display_arbiter #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    hex_display_arbiter_if.slave  bus,
    output logic [7:0]            HEX0,
    output logic [7:0]            HEX1,
    output logic [7:0]            HEX2,
    output logic [7:0]            HEX3,
    output logic [7:0]            HEX4,
    output logic [7:0]            HEX5,
    output logic                  state_dbg
);
    // HOLD_CYCLES-1 always fits in clog2(HOLD_CYCLES) bits.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {READY = 1'b0, HOLD = 1'b1} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [1:0]      ptr, ptr_d;
    logic [1:0]      owner_q, owner_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [5:0][7:0] hex_q, hex_d;

    logic [1:0]      win;
    logic [23:0]     win_value;
    logic [5:0]      win_blank;

    function automatic logic [7:0] seg_decode(input logic [3:0] n, input logic blank);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        return blank ? 8'hFF : s;
    endfunction

    // First set request searching ptr, ptr+1, ptr+2 (mod 3). ptr never holds 3.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] w;
        case (p)
            2'd0:    w = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
            2'd1:    w = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            default: w = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
        endcase
        return w;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= READY;
            cnt     <= '0;
            ptr     <= 2'd0;
            owner_q <= 2'd3;
            gnt_q   <= 3'b000;
            hex_q   <= {6{8'hFF}};
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ptr     <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            hex_q   <= hex_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ptr_d     = ptr;
        owner_d   = owner_q;
        hex_d     = hex_q;
        gnt_d     = 3'b000;
        win       = 2'd0;
        win_value = '0;
        win_blank = '0;
        case (state)
            READY: begin
                if (|bus.req) begin
                    win = rr_pick(bus.req, ptr);
                    case (win)
                        2'd0:    begin win_value = bus.req_value[23:0];  win_blank = bus.req_blank[5:0];   end
                        2'd1:    begin win_value = bus.req_value[47:24]; win_blank = bus.req_blank[11:6];  end
                        default: begin win_value = bus.req_value[71:48]; win_blank = bus.req_blank[17:12]; end
                    endcase
                    for (int d = 0; d < 6; d++) begin
                        hex_d[d] = seg_decode(win_value[4*d +: 4], win_blank[d]);
                    end
                    gnt_d   = 3'b001 << win;
                    owner_d = win;
                    ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Counter reaching zero ends the dwell; requests are ignored meanwhile.
                if (cnt == '0) state_d = READY;
                else           cnt_d   = cnt - 1'b1;
            end
            default: state_d = READY;
        endcase
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state == HOLD);
    assign state_dbg = (state == HOLD);

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
endmodule

// File: tb/tb_hex_display_arbiter.sv
module tb_hex_display_arbiter;
    localparam int H = 4;

    logic clk;
    logic reset;
    logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic state_dbg;

    hex_display_arbiter_if bus ();

    hex_display_arbiter #(.HOLD_CYCLES(H)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    initial begin
        #300000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction-level view: a grant can happen at any edge whose index is
    // >= ready_at; a grant at edge t blocks further grants until t+H+1 and
    // keeps busy high for the H cycles after it.
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int              edge_n   = 0;
    int              ready_at = 0;
    int              m_ptr    = 0;
    logic [2:0]      m_gnt;
    logic [1:0]      m_owner;
    logic            m_busy;
    logic [5:0][7:0] m_hex;
    logic [53:0]     exp_q[$];

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_hex    = {6{8'hFF}};
            m_owner  = 2'd3;
            m_gnt    = 3'b000;
            m_ptr    = 0;
            ready_at = edge_n + 1;
        end else begin
            m_gnt = 3'b000;
            if (edge_n >= ready_at && bus.req != 3'b000) begin
                w = -1;
                for (int k = 0; k < 3; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
                m_gnt[w] = 1'b1;
                for (int d = 0; d < 6; d++)
                    m_hex[d] = bus.req_blank[6*w + d] ? 8'hFF : seg_tab[bus.req_value[24*w + 4*d +: 4]];
                m_owner  = 2'(w);
                m_ptr    = (w + 1) % 3;
                ready_at = edge_n + H + 1;
            end
        end
        m_busy = (edge_n < ready_at - 1);
        exp_q.push_back({m_gnt, m_owner, m_busy, m_hex});
        edge_n++;
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [53:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outputs", 64'({bus.gnt, bus.owner, bus.busy, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(e));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("wait_idle_timeout", 64'(bus.busy), 64'(0));
    endtask

    task automatic check_hex(input string tag, input logic [47:0] exp);
        check({tag, "_hex0"}, 64'(HEX0), 64'(exp[7:0]));
        check({tag, "_hex1"}, 64'(HEX1), 64'(exp[15:8]));
        check({tag, "_hex2"}, 64'(HEX2), 64'(exp[23:16]));
        check({tag, "_hex3"}, 64'(HEX3), 64'(exp[31:24]));
        check({tag, "_hex4"}, 64'(HEX4), 64'(exp[39:32]));
        check({tag, "_hex5"}, 64'(HEX5), 64'(exp[47:40]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [2:0] seq_exp;
        reset         = 1'b1;
        bus.req       = 3'b000;
        bus.req_value = '0;
        bus.req_blank = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset then idle.
        repeat (20) @(negedge clk);
        check_hex("idle", {6{8'hFF}});
        check("idle_owner", 64'(bus.owner), 64'(3));
        check("idle_busy", 64'(bus.busy), 64'(0));
        check("idle_gnt", 64'(bus.gnt), 64'(0));

        // Single request from requester 1.
        bus.req_value[47:24] = 24'h012345;
        bus.req_blank[11:6]  = 6'b000000;
        bus.req              = 3'b010;
        @(negedge clk);
        check("single_gnt", 64'(bus.gnt), 64'(3'b010));
        check("single_owner", 64'(bus.owner), 64'(1));
        check_hex("single", 48'hC0_F9_A4_B0_99_92);
        bus.req = 3'b000;
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            @(negedge clk);
            if (n == 1) bus.req_value[47:24] = 24'hABCDEF;   // owner edits data mid-hold
        end
        check("busy_len", 64'(n), 64'(H));
        repeat (3) @(negedge clk);
        bus.req_value[47:24] = 24'h777777;                    // edit again while idle
        repeat (3) @(negedge clk);
        check_hex("stale", 48'hC0_F9_A4_B0_99_92);

        // Sustained contention from a fresh pointer.
        do_reset();
        bus.req = 3'b111;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            case (k)
                1:       seq_exp = 3'b001;
                6:       seq_exp = 3'b010;
                11:      seq_exp = 3'b100;
                16:      seq_exp = 3'b001;
                default: seq_exp = 3'b000;
            endcase
            check($sformatf("rr_gnt_c%0d", k), 64'(bus.gnt), 64'(seq_exp));
        end
        bus.req = 3'b000;

        // Blanking and the letter digits, requester 2.
        wait_idle();
        bus.req_value[71:48] = 24'hFEDCBA;
        bus.req_blank[17:12] = 6'b100001;
        bus.req              = 3'b100;
        @(negedge clk);
        check("blank_gnt", 64'(bus.gnt), 64'(3'b100));
        check_hex("blank", 48'hFF_86_A1_C6_83_FF);
        bus.req = 3'b000;

        // Reset two cycles into HOLD with requester 2 still pending.
        wait_idle();
        bus.req = 3'b100;
        @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_hex("midrst", {6{8'hFF}});
        check("midrst_owner", 64'(bus.owner), 64'(3));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("midrst_regnt", 64'(bus.gnt), 64'(3'b100));
        check("midrst_reown", 64'(bus.owner), 64'(2));
        bus.req = 3'b000;

        // Randomized traffic against the model.
        wait_idle();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) bus.req_value = {$urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 4) == 0) bus.req_blank = 18'($urandom()) & 18'($urandom());
            reset = ($urandom_range(0, 199) == 0);
        end
        reset   = 1'b0;
        bus.req = 3'b000;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
